// File: rtl/swarm_pkg.sv
// Shared constants and types for the DES task units
// and the L1 read-port arbiter.
package swarm;

    localparam int L1_ADDR_W = 32;
    localparam int L1_DATA_W = 32;

    typedef logic [L1_ADDR_W-1:0] l1_addr_t;
    typedef logic [L1_DATA_W-1:0] l1_data_t;

    // AR lock state: open for a new grant, or holding one
    typedef enum logic {
        AR_OPEN = 1'b0,
        AR_HELD = 1'b1
    } ar_state_t;

endpackage

// File: rtl/des_rd_tag_fifo.sv
// In-order tracking FIFO of requester indices for
// outstanding read bursts.
module des_rd_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_idx,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Entry storage; contents are meaningless while empty
    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_idx;
        end
    end

    // Pointers and occupancy; push+pop keeps the count
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/des_l1_rd_arbiter.sv
// Round-robin sharing of one L1 AXI read port among
// N_REQ DES task units, with in-order R steering.
module des_l1_rd_arbiter
    import swarm::*;
#(
    parameter int N_REQ = 2,
    parameter int OSTD  = 4
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [N_REQ-1:0]          req_arvalid,
    output logic [N_REQ-1:0]          req_arready,
    input  logic [N_REQ*L1_ADDR_W-1:0] req_araddr,
    input  logic [N_REQ*8-1:0]        req_arlen,
    input  logic [N_REQ*3-1:0]        req_arsize,
    output logic [N_REQ-1:0]          req_rvalid,
    input  logic [N_REQ-1:0]          req_rready,
    output logic [L1_DATA_W-1:0]      req_rdata,
    output logic                      req_rlast,
    output logic [1:0]                req_rresp,
    output logic                      m_axi_l1_V_ARVALID,
    input  logic                      m_axi_l1_V_ARREADY,
    output logic [L1_ADDR_W-1:0]      m_axi_l1_V_ARADDR,
    output logic [7:0]                m_axi_l1_V_ARLEN,
    output logic [2:0]                m_axi_l1_V_ARSIZE,
    input  logic                      m_axi_l1_V_RVALID,
    output logic                      m_axi_l1_V_RREADY,
    input  logic [L1_DATA_W-1:0]      m_axi_l1_V_RDATA,
    input  logic                      m_axi_l1_V_RLAST,
    input  logic                      m_axi_l1_V_RID,
    input  logic [1:0]                m_axi_l1_V_RRESP,
    output logic [$clog2(OSTD):0]     ostd_cnt,
    output logic                      err_unexp_r
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    l1_addr_t   araddr_a [N_REQ];
    logic [7:0] arlen_a  [N_REQ];
    logic [2:0] arsize_a [N_REQ];

    ar_state_t      ar_st;
    logic [IW-1:0]  lock_idx;
    logic [IW-1:0]  rr_ptr;
    logic           cand_vld;
    logic [IW-1:0]  cand_idx;
    logic [IW-1:0]  sel_idx;
    logic           ar_vld;
    logic           ar_hs;

    logic           fifo_full;
    logic           fifo_empty;
    logic [IW-1:0]  head;
    logic           r_pop;
    logic           unused_rid;

    assign unused_rid = m_axi_l1_V_RID;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign araddr_a[g] = req_araddr[g*L1_ADDR_W +: L1_ADDR_W];
        assign arlen_a[g]  = req_arlen[g*8 +: 8];
        assign arsize_a[g] = req_arsize[g*3 +: 3];
    end

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        int j;
        j        = 0;
        cand_vld = 1'b0;
        cand_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req_arvalid[IW'(j)]) begin
                cand_vld = 1'b1;
                cand_idx = IW'(j);
            end
        end
    end

    // Held grant wins; a new grant needs a free tag slot
    always_comb begin
        sel_idx = (ar_st == AR_HELD) ? lock_idx : cand_idx;
        ar_vld  = (ar_st == AR_HELD) || (cand_vld && !fifo_full);
        ar_hs   = ar_vld && m_axi_l1_V_ARREADY;
    end

    assign m_axi_l1_V_ARVALID = ar_vld;
    assign m_axi_l1_V_ARADDR  = araddr_a[sel_idx];
    assign m_axi_l1_V_ARLEN   = arlen_a[sel_idx];
    assign m_axi_l1_V_ARSIZE  = arsize_a[sel_idx];

    // Only the granted requester sees ARREADY
    always_comb begin
        req_arready = '0;
        if (ar_hs) begin
            req_arready[sel_idx] = 1'b1;
        end
    end

    // Lock an offered AR until accepted; advance rr_ptr
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ar_st    <= AR_OPEN;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else if (ar_hs) begin
            ar_st  <= AR_OPEN;
            rr_ptr <= (sel_idx == IW'(N_REQ - 1))
                    ? '0 : sel_idx + IW'(1);
        end else if (ar_vld) begin
            ar_st    <= AR_HELD;
            lock_idx <= sel_idx;
        end
    end

    des_rd_tag_fifo #(
        .W     (IW),
        .DEPTH (OSTD)
    ) u_tag_fifo (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .push     (ar_hs),
        .push_idx (sel_idx),
        .pop      (r_pop),
        .head     (head),
        .count    (ostd_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Steer R to the owner of the oldest burst
    always_comb begin
        req_rvalid = '0;
        if (!fifo_empty) begin
            req_rvalid[head] = m_axi_l1_V_RVALID;
        end
    end

    assign m_axi_l1_V_RREADY = !fifo_empty && req_rready[head];
    assign r_pop = m_axi_l1_V_RVALID && m_axi_l1_V_RREADY
                && m_axi_l1_V_RLAST;
    assign req_rdata = m_axi_l1_V_RDATA;
    assign req_rlast = m_axi_l1_V_RLAST;
    assign req_rresp = m_axi_l1_V_RRESP;

    // Sticky flag for R data with nothing outstanding
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_unexp_r <= 1'b0;
        end else if (m_axi_l1_V_RVALID && fifo_empty) begin
            err_unexp_r <= 1'b1;
        end
    end

endmodule
